// File: rtl/debug_monitor_if.sv
// Debug monitor bus: the observed handshake pairs, the BRAM port tap, the control
// strobes and the readout path, grouped so one instance carries the whole bundle.
interface debug_monitor_if #(
   parameter int NUM_CH = 4,
   parameter int ADDR_W = 16,
   parameter int SEL_W  = 6
);
   logic              clr_i;
   logic              arm_i;
   logic [NUM_CH-1:0] vld_i;
   logic [NUM_CH-1:0] rdy_i;
   logic [ADDR_W-1:0] addr_i;
   logic              addr_en_i;
   logic [SEL_W-1:0]  rd_sel_i;
   logic [31:0]       debug_o;
   logic [1:0]        state_o;
   logic              done_o;

   modport master (
      output clr_i, arm_i, vld_i, rdy_i, addr_i, addr_en_i, rd_sel_i,
      input  debug_o, state_o, done_o
   );

   modport slave (
      input  clr_i, arm_i, vld_i, rdy_i, addr_i, addr_en_i, rd_sel_i,
      output debug_o, state_o, done_o
   );
endinterface

// File: rtl/debug_monitor.sv
// On-chip debug monitor for the GAT pipeline: sticky flags, saturating transfer
// counters and a max-address capture over an arm/trigger-bounded window, read out
// through a registered 32-bit mux.
// Optional feature macro: DEBUG_MONITOR_STALL_EN adds per-channel stall counters
// readable at select 4+NUM_CH+c; without it those selects read zero.
//
// state | meaning
// IDLE  | after reset/clear, values held, waiting for arm
// RUN   | capture window open, all monitors active
// DONE  | trigger count or cycle saturation reached, values frozen until re-arm
module debug_monitor #(
   parameter int NUM_CH      = 4,
   parameter int CNT_W       = 32,
   parameter int ADDR_W      = 16,
   parameter int ADDR_THRESH = 43328,
   parameter int TRIG_CH     = 0,
   parameter int TRIG_CNT    = 1024,
   parameter int SEL_W       = 6
) (
   input  logic           clk,
   input  logic           rst,
   debug_monitor_if.slave dbg
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0] CNT_MAX    = '1;
   localparam logic [31:0]      TRIG_CNT_W = 32'(TRIG_CNT);
   localparam int               AW1        = ADDR_W + 1;
   localparam logic [AW1-1:0]   THRESH_W   = AW1'(ADDR_THRESH);

   state_t            state;
   logic              done_q;
   logic [31:0]       debug_q;

   logic [CNT_W-1:0]  cyc_cnt;
   logic [CNT_W-1:0]  xfer     [NUM_CH];
   logic [NUM_CH-1:0] vld_seen;
   logic [NUM_CH-1:0] rdy_seen;
   logic              ena_seen;
   logic              addr_hit;
   logic [ADDR_W-1:0] max_addr;
`ifdef DEBUG_MONITOR_STALL_EN
   logic [CNT_W-1:0]  stall    [NUM_CH];
   logic [CNT_W-1:0]  stall_nxt[NUM_CH];
`endif

   logic              run;
   logic              start;
   logic [NUM_CH-1:0] hs;
   logic [NUM_CH-1:0] xfer_inc;
   logic [CNT_W-1:0]  xfer_nxt [NUM_CH];
   logic [CNT_W-1:0]  cyc_nxt;
   logic              trig_hit;
   logic              sat_hit;
   logic              thresh_hit;
   logic [31:0]       sts_word;
   logic [31:0]       rd_word;

   assign run        = (state == ST_RUN);
   // An arm only opens a window from IDLE or DONE; a clear in the same cycle beats it.
   assign start      = dbg.arm_i && !dbg.clr_i && (state != ST_RUN);
   assign hs         = dbg.vld_i & dbg.rdy_i;
   assign thresh_hit = dbg.addr_en_i && ({1'b0, dbg.addr_i} >= THRESH_W);

   // Saturating next values and the two stop conditions.
   always_comb begin
      cyc_nxt = (cyc_cnt == CNT_MAX) ? cyc_cnt : cyc_cnt + 1'b1;
      for (int c = 0; c < NUM_CH; c++) begin
         xfer_inc[c] = hs[c] && (xfer[c] != CNT_MAX);
         xfer_nxt[c] = xfer_inc[c] ? xfer[c] + 1'b1 : xfer[c];
`ifdef DEBUG_MONITOR_STALL_EN
         stall_nxt[c] = (dbg.vld_i[c] && !dbg.rdy_i[c] && (stall[c] != CNT_MAX))
                        ? stall[c] + 1'b1 : stall[c];
`endif
      end
      trig_hit = (TRIG_CNT != 0) && xfer_inc[TRIG_CH]
                 && (32'(xfer_nxt[TRIG_CH]) == TRIG_CNT_W);
      sat_hit  = (cyc_nxt == CNT_MAX);
   end

   // Capture-window FSM with registered done flag.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= ST_IDLE;
         done_q <= 1'b0;
      end else if (dbg.clr_i) begin
         state  <= ST_IDLE;
         done_q <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (dbg.arm_i) state <= ST_RUN;
            end
            ST_RUN: begin
               if (trig_hit || sat_hit) begin
                  state  <= ST_DONE;
                  done_q <= 1'b1;
               end
            end
            ST_DONE: begin
               if (dbg.arm_i) begin
                  state  <= ST_RUN;
                  done_q <= 1'b0;
               end
            end
            default: begin
               state  <= ST_IDLE;
               done_q <= 1'b0;
            end
         endcase
      end
   end

   // Monitors: zeroed on clear or arm, updated only while the window is open.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cyc_cnt  <= '0;
         vld_seen <= '0;
         rdy_seen <= '0;
         ena_seen <= 1'b0;
         addr_hit <= 1'b0;
         max_addr <= '0;
         for (int c = 0; c < NUM_CH; c++) begin
            xfer[c] <= '0;
`ifdef DEBUG_MONITOR_STALL_EN
            stall[c] <= '0;
`endif
         end
      end else if (dbg.clr_i || start) begin
         cyc_cnt  <= '0;
         vld_seen <= '0;
         rdy_seen <= '0;
         ena_seen <= 1'b0;
         addr_hit <= 1'b0;
         max_addr <= '0;
         for (int c = 0; c < NUM_CH; c++) begin
            xfer[c] <= '0;
`ifdef DEBUG_MONITOR_STALL_EN
            stall[c] <= '0;
`endif
         end
      end else if (run) begin
         cyc_cnt  <= cyc_nxt;
         vld_seen <= vld_seen | dbg.vld_i;
         rdy_seen <= rdy_seen | dbg.rdy_i;
         if (dbg.addr_en_i) ena_seen <= 1'b1;
         if (thresh_hit) addr_hit <= 1'b1;
         if (dbg.addr_en_i && (dbg.addr_i > max_addr)) max_addr <= dbg.addr_i;
         for (int c = 0; c < NUM_CH; c++) begin
            xfer[c] <= xfer_nxt[c];
`ifdef DEBUG_MONITOR_STALL_EN
            stall[c] <= stall_nxt[c];
`endif
         end
      end
   end

   // Readout mux; the status word only has room for 16 valid and 14 ready flags.
   always_comb begin
      sts_word = '0;
      for (int c = 0; c < NUM_CH; c++) begin
         if (c < 16) sts_word[c] = vld_seen[c];
         if (c < 14) sts_word[16+c] = rdy_seen[c];
      end
      sts_word[30] = ena_seen;
      sts_word[31] = addr_hit;

      rd_word = '0;
      if (dbg.rd_sel_i == SEL_W'(0))      rd_word = sts_word;
      else if (dbg.rd_sel_i == SEL_W'(1)) rd_word = 32'(cyc_cnt);
      else if (dbg.rd_sel_i == SEL_W'(2)) rd_word = 32'(max_addr);
      else if (dbg.rd_sel_i == SEL_W'(3)) rd_word = {30'b0, state};
      for (int c = 0; c < NUM_CH; c++) begin
         if (dbg.rd_sel_i == SEL_W'(4 + c)) rd_word = 32'(xfer[c]);
`ifdef DEBUG_MONITOR_STALL_EN
         if (dbg.rd_sel_i == SEL_W'(4 + NUM_CH + c)) rd_word = 32'(stall[c]);
`endif
      end
   end

   // Registered readout, one cycle behind the select.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)            debug_q <= '0;
      else if (dbg.clr_i) debug_q <= '0;
      else                debug_q <= rd_word;
   end

   assign dbg.debug_o = debug_q;
   assign dbg.state_o = state;
   assign dbg.done_o  = done_q;

endmodule
